// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command-driven universal shift register / sequencer.
// Takes one command per valid/ready handshake. It then steps a WIDTH-bit
// register once per tick for the commanded count, and pulses done when the
// command completes.

// One register bit: picks its next value from the 2-bit mode select.
module shift_seq_bit (
    input  logic [1:0] sel,    // 00 hold, 01 take upper neighbour, 10 take lower neighbour, 11 load
    input  logic       cur,
    input  logic       hi_nb,
    input  logic       lo_nb,
    input  logic       ld,
    output logic       nxt
);
    // per-bit next-state mux
    always_comb begin
        nxt = cur;
        case (sel)
            2'b00:   nxt = cur;
            2'b01:   nxt = hi_nb;
            2'b10:   nxt = lo_nb;
            default: nxt = ld;
        endcase
    end
endmodule

module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CW-1:0]    cmd_count,
    input  logic             cmd_rotate,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_SHL  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              sout_q, sout_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic              left_q, left_d;
    logic              rot_q, rot_d;

    logic              accept;
    logic              step;
    logic [1:0]        bit_sel;
    logic              msb_in;
    logic              lsb_in;

    // A command is taken only in IDLE. A tick on that same edge is not a step,
    // because step needs state RUN.
    assign accept = (state_q == S_IDLE) && cmd_valid;
    assign step   = (state_q == S_RUN) && tick;

    // Bits entering the register ends come from the serial inputs, or from the
    // exiting bit when rotating.
    assign msb_in = rot_q ? q_q[0]       : sin_r;
    assign lsb_in = rot_q ? q_q[WIDTH-1] : sin_l;

    // Shared mode select for every bit: load on accept, shift on a RUN tick
    always_comb begin
        bit_sel = M_HOLD;
        if (accept && cmd_mode == M_LOAD)
            bit_sel = M_LOAD;
        else if (step)
            bit_sel = left_q ? M_SHL : M_SHR;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic hi_nb;
        logic lo_nb;
        if (i == WIDTH - 1) begin : g_top
            assign hi_nb = msb_in;
        end else begin : g_mid_hi
            assign hi_nb = q_q[i+1];
        end
        if (i == 0) begin : g_bot
            assign lo_nb = lsb_in;
        end else begin : g_mid_lo
            assign lo_nb = q_q[i-1];
        end
        shift_seq_bit u_bit (
            .sel   (bit_sel),
            .cur   (q_q[i]),
            .hi_nb (hi_nb),
            .lo_nb (lo_nb),
            .ld    (load_data[i]),
            .nxt   (q_d[i])
        );
    end

    // Serial output captures the bit leaving the register on each step
    always_comb begin
        sout_d = sout_q;
        if (step)
            sout_d = left_q ? q_q[WIDTH-1] : q_q[0];
    end

    // Sequencer next state: command capture, step counting, one-cycle DONE
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        left_d  = left_q;
        rot_d   = rot_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rem_d  = cmd_count;
                    left_d = (cmd_mode == M_SHL);
                    rot_d  = cmd_rotate;
                    if ((cmd_mode == M_SHR || cmd_mode == M_SHL) && cmd_count != '0)
                        state_d = S_RUN;
                    else
                        state_d = S_DONE;
                end
            end
            S_RUN: begin
                if (tick) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            rot_q   <= rot_d;
        end
    end

    assign q         = q_q;
    assign sout      = sout_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed scenarios plus random commands,
// checked against a shift-by-arithmetic reference model.
module tb_shift_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [3:0] cmd_count = 4'd0;
    logic       cmd_rotate = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] m_q = 8'h00;
    logic       m_sout = 1'b0;

    shift_seq_ctrl #(.WIDTH(8), .CW(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_count(cmd_count),
        .cmd_rotate(cmd_rotate), .load_data(load_data), .sin_r(sin_r),
        .sin_l(sin_l), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Issue one command and follow it to completion.
    // period: 0 = random ticks, N = tick every Nth RUN clock.
    // sin_fix / acc_tick: -1 = random, else fixed value.
    // stray: offer a load of FF during RUN, which must be ignored.
    // cyc returns the number of clocks from accept edge to the DONE cycle.
    task automatic run_cmd(input logic [1:0] mode, input int cnt, input bit rot,
                           input logic [7:0] ld, input int period, input int sin_fix,
                           input int acc_tick, input bit stray, output int cyc);
        int rem, guard, ph;
        bit t, sr, sl, in_b;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_wait cmd_ready=%b expected 1", cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1; cmd_mode = mode; cmd_count = cnt[3:0];
        cmd_rotate = rot; load_data = ld;
        tick = (acc_tick < 0) ? 1'($urandom_range(1)) : acc_tick[0];
        @(posedge clk);
        if (mode == 2'b11) m_q = ld;
        rem = (mode == 2'b01 || mode == 2'b10) ? cnt : 0;
        @(negedge clk);
        cmd_valid = 1'b0; tick = 1'b0;
        cmd_mode = 2'($urandom_range(3)); load_data = 8'($urandom);
        cmd_rotate = 1'($urandom_range(1));
        cyc = 1; ph = 0;
        n_chk++;
        if (q !== m_q) $display("FAIL accept_q q=%h expected %h", q, m_q);
        else n_pass++;
        while (rem > 0 && cyc < 100) begin
            n_chk++;
            if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0)
                $display("FAIL run_flags busy=%b done=%b ready=%b expected 1 0 0", busy, done, cmd_ready);
            else n_pass++;
            ph++;
            t  = (period == 0) ? ($urandom_range(1) == 1) : (ph % period == 0);
            sr = (sin_fix < 0) ? 1'($urandom_range(1)) : sin_fix[0];
            sl = (sin_fix < 0) ? 1'($urandom_range(1)) : sin_fix[0];
            tick = t; sin_r = sr; sin_l = sl;
            if (stray) begin
                cmd_valid = 1'b1; cmd_mode = 2'b11; load_data = 8'hFF;
            end
            @(posedge clk);
            if (t) begin
                if (mode == 2'b01) begin
                    in_b   = rot ? m_q[0] : sr;
                    m_sout = m_q[0];
                    m_q    = (m_q >> 1) | ({7'd0, in_b} << 7);
                end else begin
                    in_b   = rot ? m_q[7] : sl;
                    m_sout = m_q[7];
                    m_q    = (m_q << 1) | {7'd0, in_b};
                end
                rem--;
            end
            @(negedge clk);
            tick = 1'b0; cmd_valid = 1'b0;
            cyc++;
            n_chk++;
            if (q !== m_q || sout !== m_sout)
                $display("FAIL run_data q=%h sout=%b expected %h %b", q, sout, m_q, m_sout);
            else n_pass++;
        end
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0 || q !== m_q)
            $display("FAIL done_cycle done=%b busy=%b ready=%b q=%h expected 1 0 0 %h",
                     done, busy, cmd_ready, q, m_q);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL after_done done=%b busy=%b ready=%b expected 0 0 1", done, busy, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL reset q=%h sout=%b busy=%b done=%b ready=%b expected 00 0 0 0 1",
                     q, sout, busy, done, cmd_ready);
        else n_pass++;
        reset = 1'b0;
        m_q = 8'h00; m_sout = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        int cyc;
        run_cmd(2'b11, 0, 1'b0, 8'hA5, 1, 0, 0, 1'b0, cyc);
        n_chk++;
        if (q !== 8'hA5 || cyc != 1) $display("FAIL load q=%h cyc=%0d expected a5 1", q, cyc);
        else n_pass++;
    endtask

    task automatic test_shift_right();
        int cyc;
        run_cmd(2'b01, 3, 1'b0, 8'h00, 4, 1, 0, 1'b0, cyc);
        n_chk++;
        if (q !== 8'hF4 || sout !== 1'b1 || cyc != 13)
            $display("FAIL shift_right q=%h sout=%b cyc=%0d expected f4 1 13", q, sout, cyc);
        else n_pass++;
    endtask

    task automatic test_rotate_left();
        int cyc;
        run_cmd(2'b11, 0, 1'b0, 8'h81, 1, 0, 0, 1'b0, cyc);
        run_cmd(2'b10, 8, 1'b1, 8'h00, 1, 0, 0, 1'b0, cyc);
        n_chk++;
        if (q !== 8'h81 || cyc != 9) $display("FAIL rotate_left q=%h cyc=%0d expected 81 9", q, cyc);
        else n_pass++;
    endtask

    task automatic test_hold_zero();
        int cyc;
        run_cmd(2'b00, 7, 1'b0, 8'h3C, 1, 0, 1, 1'b0, cyc);
        n_chk++;
        if (q !== 8'h81 || cyc != 1) $display("FAIL hold q=%h cyc=%0d expected 81 1", q, cyc);
        else n_pass++;
        run_cmd(2'b01, 0, 1'b0, 8'h3C, 1, 0, 1, 1'b0, cyc);
        n_chk++;
        if (q !== 8'h81 || cyc != 1) $display("FAIL zero_count q=%h cyc=%0d expected 81 1", q, cyc);
        else n_pass++;
    endtask

    task automatic test_ignore_during_run();
        int cyc;
        run_cmd(2'b10, 4, 1'b0, 8'h00, 2, 0, 1, 1'b1, cyc);
        n_chk++;
        if (q !== 8'h10 || cyc != 9) $display("FAIL ignore_run q=%h cyc=%0d expected 10 9", q, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit saw_done;
        run_cmd(2'b11, 0, 1'b0, 8'hC3, 1, 0, 0, 1'b0, cyc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_count = 4'd5; cmd_rotate = 1'b0;
        tick = 1'b1; sin_r = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL reset_mid_run q=%h sout=%b busy=%b ready=%b done=%b expected 00 0 0 1 0",
                     q, sout, busy, cmd_ready, done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        tick = 1'b0;
        n_chk++;
        if (saw_done) $display("FAIL no_done_after_reset saw=%b expected 0", saw_done);
        else n_pass++;
        m_q = 8'h00; m_sout = 1'b0;
    endtask

    task automatic test_random();
        int cyc;
        logic [1:0] md;
        for (int k = 0; k < 40; k++) begin
            md = 2'($urandom_range(3));
            run_cmd(md, int'($urandom_range(15)), 1'($urandom_range(1)), 8'($urandom),
                    int'($urandom_range(3)), -1, -1, 1'($urandom_range(1)), cyc);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_rotate_left();
        test_hold_zero();
        test_ignore_during_run();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout sim_time=%0t expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
